ddr_wr_serializer: RTL and testbench
====================================

// Module: ddr_wr_serializer
// PURPOSE
//  Parametrised second-generation DDR write datapath, running entirely on clk_2x.
//  Takes 2*DQ_W-bit system words plus byte masks and serialises each word high half first.
//  Delays the beats by a programmable write latency and drives DQ, DM and DQS.
//  Adds DQS preamble/postamble, output enables and burst beat counting.
//  Sits between the command FSM (cmd_state) and the DDR pad ring.
// PARAMETERS
//  DQ_W         8                      DDR data pins; multiple of 8
//  DM_W         DQ_W/8                 data-mask pins, one per byte lane (derived, do not override)
//  DQS_W        DQ_W/8                 strobe pins; all carry identical waveform
//  BURST_LEN    4                      beats per burst; power of 2, range 2..16
//  WR_LAT       3                      clk_2x stages from beat accept to DQ pin; range 2..8
//  CMD_WR_STATE c_WAIT_END_OF_W_BURST  cmd_state code that enables beat capture
// PORTS
//  clk_2x       in   1         double-rate clock, all logic
//  rst          in   1         asynchronous, active-low reset
//  wren         in   1         system write enable
//  cmd_state    in   4         command FSM state
//  sys_data_w   in   2*DQ_W    [2*DQ_W-1:DQ_W] high half, sent first
//  sys_dm_w     in   2*DM_W    mask for each half (1 = byte masked), same split
//  wr_word_ack  out  1         comb; high on the edge consuming the low half (word done)
//  burst_done   out  1         registered 1-cycle pulse after final beat of a burst accepted
//  ddr_dq_w     out  DQ_W      DQ pin data
//  ddr_dm_w     out  DM_W      DM pin data
//  ddr_dqs_w    out  DQS_W     DQS pin data
//  ddr_dq_oe    out  1         DQ/DM output enable
//  ddr_dqs_oe   out  1         DQS output enable (includes pre/postamble)
// BEHAVIOUR
//  - Reset: all registers 0 asynchronously, mid-burst included; all outputs 0; phase=0; beat_cnt=0.
//  - accept = wren && cmd_state==CMD_WR_STATE, sampled on posedge clk_2x.
//  - Capture (posedge):
//    - accept, phase=0: stage1 <= high data/dm; phase <= 1.
//    - accept, phase=1: stage1 <= low data/dm; phase <= 0.
//    - wr_word_ack = accept & phase.
//  - !accept: phase <= 0 (realigns to high half); stage1 valid <= 0; stage1 data/dm hold.
//  - Pipeline: WR_LAT stages of {data,dm,valid}, shifted every posedge.
//    - Beat accepted at edge n is on ddr_dq_w/ddr_dm_w from edge n+WR_LAT-1.
//    - ddr_dq_oe = last-stage valid.
//  - Beat counter: beat_cnt increments per accept and wraps BURST_LEN-1 -> 0.
//    - On wrap, burst_done=1 for the next cycle.
//    - Back-to-back bursts (wren held) need no gap.
//    - !accept clears beat_cnt to 0; a partial burst never pulses burst_done.
//  - DQS (negedge clk_2x):
//    - dv = last-stage valid resampled on negedge.
//    - dv=1: ddr_dqs_w toggles every negedge; first toggle 0->1.
//    - dv=0: ddr_dqs_w forced 0.
//  - Preamble: ddr_dqs_oe rises on the negedge where stage WR_LAT-1 valid is first seen.
//    This is one clk_2x period before the first toggle, with DQS held 0.
//  - Postamble: ddr_dqs_oe stays 1 for one negedge after dv falls, DQS held 0, then falls.
//    A new preamble during postamble merges and oe stays high.
//  - Mid-burst cmd_state exit: beat refused.
//    - Already-accepted beats drain normally.
//    - DQS stops after the last valid beat, then postamble.
// STRUCTURE
//  - cmd_state codes (c_WAIT_END_OF_W_BURST etc.) come from the shared DDR parameters package.
//    No local state constants.
//  - One sub-module, ddr_dqs_gen: negedge dv resample, toggle and pre/postamble oe.
//  - Capture, pipeline and beat counter stay in the top level.
// TESTING
//  1. Reset then wren=1, state=CMD_WR_STATE, data 16'hA55A, DQ_W=8, WR_LAT=3:
//     - ddr_dq_w shows A5 then 5A from edge 2 after accept.
//     - wr_word_ack high on 2nd edge.
//     - DQS 0->1->0 on negedges.
//  2. 4 words held (8 beats, BURST_LEN=4): burst_done pulses twice, 4 cycles apart; DQS toggles 8 times continuously.
//  3. sys_dm_w=2'b10, data 16'h1234: ddr_dm_w=1 while 12 on DQ, 0 while 34 on DQ.
//  4. wren drops after 3 beats: no burst_done; phase and beat_cnt 0; next word starts high half; DQS oe postamble exactly one period.
//  5. rst low mid-burst: all outputs 0 immediately; after release, a new word outputs high half first.
//  6. DQ_W=16, WR_LAT=5, data 32'hDEADBEEF: DEAD then BEEF at edge n+4; both DQS bits identical.

Source files
------------

// File: rtl/ddr_wr_serializer_pkg.sv
// Shared DDR command FSM state codes and common widths.
// Imported by the write datapath and its DQS generator.
package ddr_wr_serializer_pkg;

   localparam int CMD_STATE_W = 4;

   typedef enum logic [CMD_STATE_W-1:0] {
      c_IDLE                = 4'd0,
      c_ACTIVATE            = 4'd1,
      c_WAIT_TRCD           = 4'd2,
      c_WRITE               = 4'd3,
      c_WAIT_END_OF_W_BURST = 4'd4,
      c_READ                = 4'd5,
      c_WAIT_END_OF_R_BURST = 4'd6,
      c_PRECHARGE           = 4'd7,
      c_REFRESH             = 4'd8
   } cmd_state_e;

endpackage

// File: rtl/ddr_wr_serializer_dqs_gen.sv
// DQS strobe generator: negedge resample of the last-stage valid,
// strobe toggling, and output enable with one-period pre/postamble.
// Ports: clk_2x, rst (async, active-low), pre_vld (stage WR_LAT-1 valid),
//        last_vld (last-stage valid), ddr_dqs_w, ddr_dqs_oe.
module ddr_dqs_gen
   import ddr_wr_serializer_pkg::*;
#(
   parameter int DQS_W = 1
) (
   input  logic             clk_2x,
   input  logic             rst,
   input  logic             pre_vld,
   input  logic             last_vld,
   output logic [DQS_W-1:0] ddr_dqs_w,
   output logic             ddr_dqs_oe
);

   logic dv;
   logic tog;
   logic oe;

   // Strobe edges land mid-beat because everything here runs on negedge.
   // oe covers: next beat coming (preamble), current beat, and one
   // period after the last beat (dv still holds the previous sample).
   always_ff @(negedge clk_2x or negedge rst) begin
      if (!rst) begin
         dv  <= 1'b0;
         tog <= 1'b0;
         oe  <= 1'b0;
      end else begin
         dv  <= last_vld;
         tog <= last_vld ? ~tog : 1'b0;
         oe  <= pre_vld | last_vld | dv;
      end
   end

   assign ddr_dqs_w  = {DQS_W{tog}};
   assign ddr_dqs_oe = oe;

endmodule

// File: rtl/ddr_wr_serializer.sv
// DDR write datapath: splits each 2*DQ_W word into two beats (high first),
// delays them WR_LAT clk_2x stages, counts burst beats, drives DQ/DM/DQS.
// Ports: clk_2x, rst (async, active-low), wren, cmd_state, sys_data_w,
//        sys_dm_w, wr_word_ack, burst_done, ddr_dq_w, ddr_dm_w, ddr_dqs_w,
//        ddr_dq_oe, ddr_dqs_oe.
module ddr_wr_serializer
   import ddr_wr_serializer_pkg::*;
#(
   parameter int         DQ_W         = 8,
   parameter int         DQS_W        = DQ_W / 8,
   parameter int         BURST_LEN    = 4,
   parameter int         WR_LAT       = 3,
   parameter cmd_state_e CMD_WR_STATE = c_WAIT_END_OF_W_BURST,
   localparam int        DM_W         = DQ_W / 8
) (
   input  logic                   clk_2x,
   input  logic                   rst,
   input  logic                   wren,
   input  logic [CMD_STATE_W-1:0] cmd_state,
   input  logic [2*DQ_W-1:0]      sys_data_w,
   input  logic [2*DM_W-1:0]      sys_dm_w,
   output logic                   wr_word_ack,
   output logic                   burst_done,
   output logic [DQ_W-1:0]        ddr_dq_w,
   output logic [DM_W-1:0]        ddr_dm_w,
   output logic [DQS_W-1:0]       ddr_dqs_w,
   output logic                   ddr_dq_oe,
   output logic                   ddr_dqs_oe
);

   localparam int CNT_W = $clog2(BURST_LEN);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

   logic              accept;
   logic              phase;
   logic [DQ_W-1:0]   beat_dq;
   logic [DM_W-1:0]   beat_dm;
   logic [DQ_W-1:0]   dq_pipe [WR_LAT];
   logic [DM_W-1:0]   dm_pipe [WR_LAT];
   logic [WR_LAT-1:0] vld_pipe;
   logic [CNT_W-1:0]  beat_cnt;
   logic              bd_q;

   assign accept      = wren && (cmd_state == CMD_WR_STATE);
   assign wr_word_ack = accept && phase;

   // phase=0 selects the high half; any refused cycle realigns to it.
   assign beat_dq = phase ? sys_data_w[DQ_W-1:0]
                          : sys_data_w[2*DQ_W-1:DQ_W];
   assign beat_dm = phase ? sys_dm_w[DM_W-1:0]
                          : sys_dm_w[2*DM_W-1:DM_W];

   always_ff @(posedge clk_2x or negedge rst) begin
      if (!rst) begin
         phase    <= 1'b0;
         vld_pipe <= '0;
         beat_cnt <= '0;
         bd_q     <= 1'b0;
         for (int i = 0; i < WR_LAT; i++) begin
            dq_pipe[i] <= '0;
            dm_pipe[i] <= '0;
         end
      end else begin
         phase    <= accept && !phase;
         vld_pipe <= {vld_pipe[WR_LAT-2:0], accept};
         if (accept) begin
            dq_pipe[0] <= beat_dq;
            dm_pipe[0] <= beat_dm;
         end
         for (int i = 1; i < WR_LAT; i++) begin
            dq_pipe[i] <= dq_pipe[i-1];
            dm_pipe[i] <= dm_pipe[i-1];
         end
         // A refused cycle abandons any partial burst.
         if (!accept) begin
            beat_cnt <= '0;
         end else if (beat_cnt == LAST_BEAT) begin
            beat_cnt <= '0;
         end else begin
            beat_cnt <= beat_cnt + CNT_W'(1);
         end
         bd_q <= accept && (beat_cnt == LAST_BEAT);
      end
   end

   assign burst_done = bd_q;
   assign ddr_dq_w   = dq_pipe[WR_LAT-1];
   assign ddr_dm_w   = dm_pipe[WR_LAT-1];
   assign ddr_dq_oe  = vld_pipe[WR_LAT-1];

   ddr_dqs_gen #(
      .DQS_W (DQS_W)
   ) u_dqs_gen (
      .clk_2x     (clk_2x),
      .rst        (rst),
      .pre_vld    (vld_pipe[WR_LAT-2]),
      .last_vld   (vld_pipe[WR_LAT-1]),
      .ddr_dqs_w  (ddr_dqs_w),
      .ddr_dqs_oe (ddr_dqs_oe)
   );

endmodule

// File: tb/tb_ddr_wr_serializer.sv
// Bench for ddr_wr_serializer: two instances (8-bit/lat 3, 16-bit/lat 5)
// checked every cycle against an edge-indexed beat model plus literals.
module tb_ddr_wr_serializer;
   import ddr_wr_serializer_pkg::*;

   localparam int LA = 3;
   localparam int LB = 5;
   localparam int BL = 4;
   localparam int NE = 4096;
   localparam logic [3:0] WRS = c_WAIT_END_OF_W_BURST;

   logic clk_2x = 1'b0;
   logic rst    = 1'b0;
   always #5 clk_2x = ~clk_2x;

   logic        wren_a = 1'b0;
   logic [3:0]  cmd_a  = WRS;
   logic [15:0] data_a = '0;
   logic [1:0]  dmi_a  = '0;
   logic        ack_a, bd_a, dqoe_a, dqsoe_a;
   logic [7:0]  dq_a;
   logic [0:0]  dm_a, dqs_a;

   logic        wren_b = 1'b0;
   logic [3:0]  cmd_b  = WRS;
   logic [31:0] data_b = '0;
   logic [3:0]  dmi_b  = '0;
   logic        ack_b, bd_b, dqoe_b, dqsoe_b;
   logic [15:0] dq_b;
   logic [1:0]  dm_b, dqs_b;

   ddr_wr_serializer #(
      .DQ_W(8), .BURST_LEN(BL), .WR_LAT(LA), .CMD_WR_STATE(c_WAIT_END_OF_W_BURST)
   ) u_a (
      .clk_2x(clk_2x), .rst(rst), .wren(wren_a), .cmd_state(cmd_a),
      .sys_data_w(data_a), .sys_dm_w(dmi_a), .wr_word_ack(ack_a),
      .burst_done(bd_a), .ddr_dq_w(dq_a), .ddr_dm_w(dm_a),
      .ddr_dqs_w(dqs_a), .ddr_dq_oe(dqoe_a), .ddr_dqs_oe(dqsoe_a)
   );

   ddr_wr_serializer #(
      .DQ_W(16), .BURST_LEN(BL), .WR_LAT(LB), .CMD_WR_STATE(c_WAIT_END_OF_W_BURST)
   ) u_b (
      .clk_2x(clk_2x), .rst(rst), .wren(wren_b), .cmd_state(cmd_b),
      .sys_data_w(data_b), .sys_dm_w(dmi_b), .wr_word_ack(ack_b),
      .burst_done(bd_b), .ddr_dq_w(dq_b), .ddr_dm_w(dm_b),
      .ddr_dqs_w(dqs_b), .ddr_dq_oe(dqoe_b), .ddr_dqs_oe(dqsoe_b)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: pv[i][e] = a beat is on the pins after posedge e.
   bit          pv  [2][NE];
   logic [15:0] pd  [2][NE];
   logic [1:0]  pm  [2][NE];
   bit          bdx [2][NE];
   int          ec = 16;
   int          run [2];

   task automatic model_edge(input int i, input bit acc, input logic [31:0] d,
                             input logic [3:0] m, input int L, input int W);
      logic [31:0] dmask, hd, ld;
      logic [3:0]  mmask, hm, lm;
      int          mw;
      mw    = W / 8;
      dmask = (32'd1 << W) - 32'd1;
      mmask = 4'((32'd1 << mw) - 32'd1);
      hd    = (d >> W) & dmask;
      ld    = d & dmask;
      hm    = (m >> mw) & mmask;
      lm    = m & mmask;
      if (acc) begin
         pv[i][ec+L-1] = 1'b1;
         pd[i][ec+L-1] = (run[i] % 2 == 0) ? 16'(hd) : 16'(ld);
         pm[i][ec+L-1] = (run[i] % 2 == 0) ? 2'(hm) : 2'(lm);
         run[i]++;
         if (run[i] % BL == 0) bdx[i][ec] = 1'b1;
      end else begin
         run[i] = 0;
      end
   endtask

   always @(posedge clk_2x or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 2; i++) begin
            run[i] = 0;
            for (int k = ec - 2; k <= ec + 12; k++) begin
               pv[i][k]  = 1'b0;
               bdx[i][k] = 1'b0;
            end
         end
      end else begin
         ec++;
         model_edge(0, wren_a && cmd_a == WRS, {16'h0, data_a}, {2'b0, dmi_a}, LA, 8);
         model_edge(1, wren_b && cmd_b == WRS, data_b, dmi_b, LB, 16);
      end
   end

   function automatic bit exp_dqs(input int i, input int e);
      int k;
      if (!pv[i][e]) return 1'b0;
      k = 1;
      while (k < e && pv[i][e-k]) k++;
      return (k % 2 == 1);
   endfunction

   function automatic bit exp_oe(input int i, input int e);
      return pv[i][e-1] | pv[i][e] | pv[i][e+1];
   endfunction

   // Single compare process: posedge-side outputs, then strobe outputs.
   initial forever begin
      @(posedge clk_2x);
      #3;
      if (rst) begin
         chk("m_dqoe_a", 32'(dqoe_a), 32'(pv[0][ec]));
         chk("m_dqoe_b", 32'(dqoe_b), 32'(pv[1][ec]));
         if (pv[0][ec]) begin
            chk("m_dq_a", 32'(dq_a), 32'(pd[0][ec][7:0]));
            chk("m_dm_a", 32'(dm_a), 32'(pm[0][ec][0]));
         end
         if (pv[1][ec]) begin
            chk("m_dq_b", 32'(dq_b), 32'(pd[1][ec]));
            chk("m_dm_b", 32'(dm_b), 32'(pm[1][ec]));
         end
         chk("m_bd_a", 32'(bd_a), 32'(bdx[0][ec]));
         chk("m_bd_b", 32'(bd_b), 32'(bdx[1][ec]));
         chk("m_ack_a", 32'(ack_a), 32'(wren_a && cmd_a == WRS && run[0] % 2 == 1));
         chk("m_ack_b", 32'(ack_b), 32'(wren_b && cmd_b == WRS && run[1] % 2 == 1));
      end
      @(negedge clk_2x);
      #3;
      if (rst) begin
         chk("m_dqs_a", 32'(dqs_a), 32'(exp_dqs(0, ec)));
         chk("m_dqs_b", 32'(dqs_b), 32'({2{exp_dqs(1, ec)}}));
         chk("m_dqsoe_a", 32'(dqsoe_a), 32'(exp_oe(0, ec)));
         chk("m_dqsoe_b", 32'(dqsoe_b), 32'(exp_oe(1, ec)));
      end
   end

   int   bd_cnt = 0, bd_last = 0, bd_prev = 0;
   int   tog_cnt = 0, oe_hi = 0;
   logic dqs_prev = 1'b0;

   always @(negedge clk_2x) begin
      if (bd_a) begin
         bd_cnt++;
         bd_prev = bd_last;
         bd_last = ec;
      end
   end

   always @(posedge clk_2x) begin
      if (dqs_a[0] != dqs_prev) tog_cnt++;
      dqs_prev = dqs_a[0];
      if (dqsoe_a) oe_hi++;
   end

   task automatic step();
      @(posedge clk_2x);
      #1;
   endtask

   task automatic negs();
      @(negedge clk_2x);
      #1;
   endtask

   int b0, t0, o0;

   initial begin
      repeat (3) step();
      chk("rst_dq", 32'(dq_a), 32'h0);
      chk("rst_dqsoe", 32'(dqsoe_a), 32'h0);
      chk("rst_ack", 32'(ack_a), 32'h0);
      rst = 1'b1;
      repeat (2) step();

      // 1: single word A55A
      data_a = 16'hA55A;
      wren_a = 1'b1;
      chk("t1_ack_first", 32'(ack_a), 32'h0);
      step();
      chk("t1_ack_second", 32'(ack_a), 32'h1);
      step();
      wren_a = 1'b0;
      negs();
      chk("t1_pre_oe", 32'(dqsoe_a), 32'h1);
      chk("t1_pre_dqs", 32'(dqs_a), 32'h0);
      step();
      chk("t1_dq_hi", 32'(dq_a), 32'hA5);
      chk("t1_dqoe", 32'(dqoe_a), 32'h1);
      negs();
      chk("t1_dqs_rise", 32'(dqs_a), 32'h1);
      step();
      chk("t1_dq_lo", 32'(dq_a), 32'h5A);
      negs();
      chk("t1_dqs_fall", 32'(dqs_a), 32'h0);
      step();
      negs();
      chk("t1_post_oe", 32'(dqsoe_a), 32'h1);
      step();
      negs();
      chk("t1_oe_off", 32'(dqsoe_a), 32'h0);
      repeat (3) step();

      // 2: four words back to back
      b0 = bd_cnt;
      t0 = tog_cnt;
      wren_a = 1'b1;
      for (int w = 0; w < 4; w++) begin
         data_a = 16'h1122 + 16'(w) * 16'h1111;
         step();
         step();
      end
      wren_a = 1'b0;
      repeat (10) step();
      chk("t2_bd_count", 32'(bd_cnt - b0), 32'd2);
      chk("t2_bd_gap", 32'(bd_last - bd_prev), 32'd4);
      chk("t2_dqs_toggles", 32'(tog_cnt - t0), 32'd8);

      // 3: data mask on high half only
      data_a = 16'h1234;
      dmi_a  = 2'b10;
      wren_a = 1'b1;
      step();
      step();
      wren_a = 1'b0;
      step();
      chk("t3_dq_hi", 32'(dq_a), 32'h12);
      chk("t3_dm_hi", 32'(dm_a), 32'h1);
      step();
      chk("t3_dq_lo", 32'(dq_a), 32'h34);
      chk("t3_dm_lo", 32'(dm_a), 32'h0);
      dmi_a = 2'b00;
      repeat (4) step();

      // 4: partial burst of three beats
      b0 = bd_cnt;
      o0 = oe_hi;
      data_a = 16'hC3D4;
      wren_a = 1'b1;
      step();
      step();
      data_a = 16'hE5F6;
      step();
      wren_a = 1'b0;
      repeat (8) step();
      chk("t4_no_bd", 32'(bd_cnt - b0), 32'd0);
      chk("t4_oe_len", 32'(oe_hi - o0), 32'd5);
      data_a = 16'h9A7B;
      wren_a = 1'b1;
      step();
      step();
      wren_a = 1'b0;
      step();
      chk("t4_realign_hi", 32'(dq_a), 32'h9A);
      step();
      chk("t4_realign_lo", 32'(dq_a), 32'h7B);
      repeat (4) step();

      // 5: reset mid-burst
      data_a = 16'hE1F2;
      wren_a = 1'b1;
      repeat (4) step();
      chk("t5_active", 32'(dqoe_a), 32'h1);
      rst    = 1'b0;
      wren_a = 1'b0;
      #1;
      chk("t5_dq", 32'(dq_a), 32'h0);
      chk("t5_dm", 32'(dm_a), 32'h0);
      chk("t5_dqs", 32'(dqs_a), 32'h0);
      chk("t5_dqoe", 32'(dqoe_a), 32'h0);
      chk("t5_dqsoe", 32'(dqsoe_a), 32'h0);
      chk("t5_bd", 32'(bd_a), 32'h0);
      chk("t5_ack", 32'(ack_a), 32'h0);
      step();
      step();
      rst    = 1'b1;
      data_a = 16'h6789;
      wren_a = 1'b1;
      step();
      step();
      wren_a = 1'b0;
      step();
      chk("t5_hi_first", 32'(dq_a), 32'h67);
      step();
      chk("t5_lo", 32'(dq_a), 32'h89);
      repeat (4) step();

      // 6: wide instance, latency 5
      data_b = 32'hDEADBEEF;
      dmi_b  = 4'b0110;
      wren_b = 1'b1;
      step();
      chk("t6_ack", 32'(ack_b), 32'h1);
      step();
      wren_b = 1'b0;
      step();
      step();
      chk("t6_not_yet", 32'(dqoe_b), 32'h0);
      step();
      chk("t6_dq_hi", 32'(dq_b), 32'hDEAD);
      chk("t6_dm_hi", 32'(dm_b), 32'h1);
      negs();
      chk("t6_dqs_rise", 32'(dqs_b), 32'h3);
      step();
      chk("t6_dq_lo", 32'(dq_b), 32'hBEEF);
      chk("t6_dm_lo", 32'(dm_b), 32'h2);
      negs();
      chk("t6_dqs_fall", 32'(dqs_b), 32'h0);
      repeat (6) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
